// File: rtl/uart_rx_core.sv
// ============================================================================
// Module   : uart_rx_core
// Purpose  : Asynchronous UART receiver, 8N1 (or 8E1/8O1), mid-bit sampling.
//            Double-flop synchronizer, start-bit glitch rejection, framing
//            error / break handling, single-cycle rx_vld strobe.
// Options  : define UART_RX_PARITY_EN to add a parity bit after the data bits
//            (PARITY_ODD selects even (0) or odd (1) parity).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int          DIV       = CLK_HZ / BAUD;
  localparam int          HALF      = DIV / 2;
  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  // Bad configurations are caught at elaboration rather than in the field.
  if (DIV < 4) begin : g_bad_div
    $error("uart_rx_core: CLK_HZ/BAUD must be at least 4");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_rx_core: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
`ifdef UART_RX_PARITY_EN
    , PAR = 3'd5
`endif
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic        rx_d;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic        par_bit;
`endif

  // The state register itself is the busy indication; no extra flop needed.
  assign busy = (state != IDLE);

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Frame FSM: bit timing, shifting, and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      rx_vld     <= 1'b0;
      rx_data    <= 8'h00;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      rx_vld     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      cnt        <= cnt + 16'd1;
      case (state)
        IDLE: begin
          if (!rx_s && rx_d) begin
            state <= START;
            cnt   <= 16'd0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end
        end
        DATA: begin
          // Counter restarts at each bit so every sample lands mid-bit.
          if (cnt == DIV_LAST) begin
            cnt     <= 16'd0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PAR;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PAR: begin
          if (cnt == DIV_LAST) begin
            cnt     <= 16'd0;
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch the next start.
          if (cnt == DIV_LAST) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state   <= IDLE;
              rx_vld  <= 1'b1;
              rx_data <= shreg;
`ifdef UART_RX_PARITY_EN
              parity_err <= ((^shreg) ^ par_bit) != PAR_ODD;
`endif
            end else begin
              state     <= BRK;
              frame_err <= 1'b1;
            end
          end
        end
        BRK: begin
          if (rx_s) begin
            state <= IDLE;
            cnt   <= 16'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Directed self-checking bench for uart_rx_core at default
//            parameters (DIV=217, HALF=108). Honours UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_core;

  localparam int DIV  = 217;
  localparam int HALF = 108;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Edge at which the stop bit is sampled (rx_vld is set by that edge),
  // counted from the edge where rx_m first captures the start level.
  localparam int STOP_OFS = 2 + HALF + (FRAME_BITS - 1) * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_vld;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [7:0] vld_data[$];
  int         vld_cyc[$];
  logic       vld_perr[$];
  int         ferr_cnt  = 0;
  int         dbl_cnt   = 0;
  int         since_vld = 1000;
  logic       busy_after2 = 1'b1;
  logic       prev_vld = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

  uart_rx_core dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc++;

  // Capture strobes away from the active edge; cyc here equals the edge that set them.
  always @(negedge clk) begin
    if (rx_vld) begin
      vld_data.push_back(rx_data);
      vld_cyc.push_back(cyc);
      vld_perr.push_back(parity_err);
      since_vld = 0;
    end else if (since_vld < 1000) begin
      since_vld++;
    end
    if (since_vld == 2) busy_after2 = busy;
    if (frame_err) ferr_cnt++;
    if ((rx_vld && prev_vld) || (frame_err && prev_ferr) || (parity_err && prev_perr))
      dbl_cnt++;
    prev_vld  = rx_vld;
    prev_ferr = frame_err;
    prev_perr = parity_err;
  end

  function automatic logic good_par(input logic [7:0] d);
    return ^d;  // even parity at default PARITY_ODD=0
  endfunction

  // Drives one frame; entered and left right after a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic stop_bit);
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = pb;
    repeat (DIV) @(negedge clk);
`else
    if (pb) begin end
`endif
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    total++; if (rx_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", rx_vld); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    rst = 1'b0;
    repeat (DIV) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    total++; if (vld_data.size() !== 0) begin bad++; $display("FAIL idle_vld got=%0d exp=0", vld_data.size()); end
  endtask

  task automatic test_single;
    int n0, f0;
    logic [7:0] d;
    int lat;
    n0 = vld_data.size(); f0 = ferr_cnt;
    send_frame(8'h55, good_par(8'h55), 1'b1);
    repeat (4) @(negedge clk);
    d   = (vld_data.size() > n0) ? vld_data[n0] : 8'hxx;
    lat = (vld_cyc.size() > n0) ? vld_cyc[n0] - t0 : -1;
    total++; if (vld_data.size() !== n0 + 1) begin bad++; $display("FAIL single_count got=%0d exp=%0d", vld_data.size() - n0, 1); end
    total++; if (d !== 8'h55) begin bad++; $display("FAIL single_data got=%h exp=55", d); end
    total++; if (lat !== STOP_OFS) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, STOP_OFS); end
    total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL single_ferr got=%0d exp=%0d", ferr_cnt, f0); end
    total++; if (busy_after2 !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy_after2); end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = vld_data.size(); f0 = ferr_cnt;
    rx = 1'b0;
    t0 = cyc + 1;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    while (cyc < t0 + HALF + 1) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
    repeat (3 * DIV) @(negedge clk);
    total++; if (vld_data.size() !== n0) begin bad++; $display("FAIL glitch_vld got=%0d exp=%0d", vld_data.size(), n0); end
    total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL glitch_ferr got=%0d exp=%0d", ferr_cnt, f0); end
  endtask

  task automatic test_back_to_back;
    int n0, gap;
    logic [7:0] d0, d1;
    n0 = vld_data.size();
    send_frame(8'h00, good_par(8'h00), 1'b1);
    send_frame(8'hFF, good_par(8'hFF), 1'b1);
    repeat (8) @(negedge clk);
    d0  = (vld_data.size() > n0)     ? vld_data[n0]     : 8'hxx;
    d1  = (vld_data.size() > n0 + 1) ? vld_data[n0 + 1] : 8'hxx;
    gap = (vld_cyc.size() > n0 + 1)  ? vld_cyc[n0 + 1] - vld_cyc[n0] : -1;
    total++; if (vld_data.size() !== n0 + 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", vld_data.size() - n0); end
    total++; if (d0 !== 8'h00) begin bad++; $display("FAIL b2b_data0 got=%h exp=00", d0); end
    total++; if (d1 !== 8'hFF) begin bad++; $display("FAIL b2b_data1 got=%h exp=ff", d1); end
    total++; if (gap < FRAME_BITS * DIV - 2 || gap > FRAME_BITS * DIV + 2) begin
      bad++; $display("FAIL b2b_spacing got=%0d exp=%0d+-2", gap, FRAME_BITS * DIV); end
    total++; if (dbl_cnt !== 0) begin bad++; $display("FAIL strobe_double got=%0d exp=0", dbl_cnt); end
  endtask

  task automatic test_frame_err;
    int n0, f0;
    logic [7:0] d;
    n0 = vld_data.size(); f0 = ferr_cnt;
    send_frame(8'hA5, good_par(8'hA5), 1'b0);
    repeat (30 * DIV) @(negedge clk);
    total++; if (ferr_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_count got=%0d exp=%0d", ferr_cnt - f0, 1); end
    total++; if (vld_data.size() !== n0) begin bad++; $display("FAIL ferr_vld got=%0d exp=0", vld_data.size() - n0); end
    total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL ferr_data_held got=%h exp=ff", rx_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy got=%b exp=1", busy); end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_exit got=%b exp=0", busy); end
    send_frame(8'h3C, good_par(8'h3C), 1'b1);
    repeat (4) @(negedge clk);
    d = (vld_data.size() > n0) ? vld_data[n0] : 8'hxx;
    total++; if (vld_data.size() !== n0 + 1) begin bad++; $display("FAIL after_break_count got=%0d exp=1", vld_data.size() - n0); end
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL after_break_data got=%h exp=3c", d); end
  endtask

  task automatic test_reset_mid_frame;
    int n0, f0;
    logic [7:0] d;
    logic [7:0] b;
    n0 = vld_data.size(); f0 = ferr_cnt;
    b  = 8'h81;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = b[4];
    repeat (DIV / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", rx_data); end
    total++; if ({rx_vld, frame_err, parity_err} !== 3'b000) begin
      bad++; $display("FAIL rst_strobes got=%b exp=000", {rx_vld, frame_err, parity_err}); end
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * DIV) @(negedge clk);
    total++; if (vld_data.size() !== n0 || ferr_cnt !== f0) begin
      bad++; $display("FAIL rst_abort got=%0d/%0d exp=0/0", vld_data.size() - n0, ferr_cnt - f0); end
    send_frame(8'h81, good_par(8'h81), 1'b1);
    repeat (4) @(negedge clk);
    d = (vld_data.size() > n0) ? vld_data[n0] : 8'hxx;
    total++; if (d !== 8'h81) begin bad++; $display("FAIL rst_rerx_data got=%h exp=81", d); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0;
    logic [7:0] d0, d1;
    logic p0, p1;
    n0 = vld_data.size();
    send_frame(8'hA5, 1'b1, 1'b1);  // A5 has four ones: parity 1 is wrong
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    d0 = (vld_data.size() > n0)     ? vld_data[n0]     : 8'hxx;
    d1 = (vld_data.size() > n0 + 1) ? vld_data[n0 + 1] : 8'hxx;
    p0 = (vld_perr.size() > n0)     ? vld_perr[n0]     : 1'bx;
    p1 = (vld_perr.size() > n0 + 1) ? vld_perr[n0 + 1] : 1'bx;
    total++; if (vld_data.size() !== n0 + 2) begin bad++; $display("FAIL par_count got=%0d exp=2", vld_data.size() - n0); end
    total++; if (p0 !== 1'b1) begin bad++; $display("FAIL par_err_bad got=%b exp=1", p0); end
    total++; if (p1 !== 1'b0) begin bad++; $display("FAIL par_err_good got=%b exp=0", p1); end
    total++; if (d0 !== 8'hA5 || d1 !== 8'hA5) begin bad++; $display("FAIL par_data got=%h/%h exp=a5/a5", d0, d1); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    test_reset();
    test_single();
    test_glitch();
    test_back_to_back();
    test_frame_err();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
